rf_port_sched: RTL

- Scheduler for the 32x32 register file's single write port and its read1 port.
- Arbitrates register writeback between two requesters, the ALU writeback and the load/MEM writeback, using round-robin priority and a valid/ready handshake.
- Also sequences a full register-file dump: it walks every address on the read1 port, streams the contents out with address tags, and blocks writes for the duration.
- Sits between the pipeline writeback stage and the register file.

---
 rtl/rf_port_sched.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rf_port_sched.sv
// rf_port_sched: schedules the register file's single write port between the
// ALU and MEM writeback requesters (round-robin, valid/ready), and sequences a
// full register-file dump over the read1 port. Writes stall while a dump runs.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   alu_wb_valid/reg/data, _ready    ALU writeback request and accept
//   mem_wb_valid/reg/data, _ready    MEM writeback request and accept
//   dump_req                         start a dump (sampled in IDLE only)
//   rf_write/rf_writereg/rf_writedata register-file write port (registered)
//   rf_read1, rf_data1               register-file read1 address / data
//   dump_busy, dump_valid, dump_addr, dump_data, dump_done  dump stream
module rf_port_sched #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned NREGS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_wb_valid,
  input  logic [AW-1:0] alu_wb_reg,
  input  logic [DW-1:0] alu_wb_data,
  output logic          alu_wb_ready,
  input  logic          mem_wb_valid,
  input  logic [AW-1:0] mem_wb_reg,
  input  logic [DW-1:0] mem_wb_data,
  output logic          mem_wb_ready,
  input  logic          dump_req,
  output logic          rf_write,
  output logic [AW-1:0] rf_writereg,
  output logic [DW-1:0] rf_writedata,
  output logic [AW-1:0] rf_read1,
  input  logic [DW-1:0] rf_data1,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          dump_done
);

  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DUMP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic ptr_mem;      // 1: MEM has priority on contention (ALU granted last)
  logic rd_live;      // rf_read1 presents an address not yet captured
  logic arb_ok;
  logic alu_pick;
  logic alu_gnt, mem_gnt;

  logic          ptr_mem_nxt, rd_live_nxt;
  logic          wr_nxt;
  logic [AW-1:0] wreg_nxt, read1_nxt, daddr_nxt;
  logic [DW-1:0] wdata_nxt, ddata_nxt;
  logic          dvalid_nxt, ddone_nxt, busy_nxt;

  // Arbitration: ALU wins unless MEM is requesting and either ALU is idle or
  // it is MEM's turn. This keeps at most one ready high in every cycle.
  assign arb_ok       = rst_n & (state == S_IDLE) & ~dump_req;
  assign alu_pick     = mem_wb_valid ? (alu_wb_valid & ~ptr_mem) : 1'b1;
  assign alu_wb_ready = arb_ok & alu_pick;
  assign mem_wb_ready = arb_ok & ~alu_pick;
  assign alu_gnt      = alu_wb_ready & alu_wb_valid;
  assign mem_gnt      = mem_wb_ready & mem_wb_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    ptr_mem_nxt = ptr_mem;
    rd_live_nxt = rd_live;
    read1_nxt   = rf_read1;
    dvalid_nxt  = 1'b0;
    daddr_nxt   = dump_addr;
    ddata_nxt   = dump_data;
    wr_nxt      = alu_gnt | mem_gnt;
    wreg_nxt    = rf_writereg;
    wdata_nxt   = rf_writedata;

    if (alu_gnt) begin
      wreg_nxt  = alu_wb_reg;
      wdata_nxt = alu_wb_data;
    end else if (mem_gnt) begin
      wreg_nxt  = mem_wb_reg;
      wdata_nxt = mem_wb_data;
    end

    case (state)
      S_IDLE: begin
        if (dump_req)     state_nxt   = S_DRAIN;
        else if (alu_gnt) ptr_mem_nxt = 1'b1;
        else if (mem_gnt) ptr_mem_nxt = 1'b0;
      end
      S_DRAIN: begin
        state_nxt   = S_DUMP;
        read1_nxt   = '0;
        rd_live_nxt = 1'b1;
      end
      S_DUMP: begin
        // Capture the word addressed last cycle; leave once the final word
        // has been presented on dump_data.
        if (rd_live) begin
          dvalid_nxt = 1'b1;
          daddr_nxt  = rf_read1;
          ddata_nxt  = rf_data1;
          if (rf_read1 == LAST_REG) rd_live_nxt = 1'b0;
          else                      read1_nxt   = rf_read1 + AW'(1);
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    ddone_nxt = (state_nxt == S_DONE);
    busy_nxt  = (state_nxt != S_IDLE);
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_mem      <= 1'b0;
      rd_live      <= 1'b0;
      rf_write     <= 1'b0;
      rf_writereg  <= '0;
      rf_writedata <= '0;
      rf_read1     <= '0;
      dump_busy    <= 1'b0;
      dump_valid   <= 1'b0;
      dump_addr    <= '0;
      dump_data    <= '0;
      dump_done    <= 1'b0;
    end else begin
      ptr_mem      <= ptr_mem_nxt;
      rd_live      <= rd_live_nxt;
      rf_write     <= wr_nxt;
      rf_writereg  <= wreg_nxt;
      rf_writedata <= wdata_nxt;
      rf_read1     <= read1_nxt;
      dump_busy    <= busy_nxt;
      dump_valid   <= dvalid_nxt;
      dump_addr    <= daddr_nxt;
      dump_data    <= ddata_nxt;
      dump_done    <= ddone_nxt;
    end
  end

endmodule
